tdm_demux_ctrl: RTL and testbench

- Time-division scheduler that drives the select lines of the 1-to-8 demultiplexer.
- Accepts a serial data stream over a valid/ready handshake and routes each accepted beat to the next enabled output channel, round-robin.
- Emits a registered one-hot channel strobe and frame markers, so downstream per-channel logic captures only its own slot.
- Sits between the serial source and the demux/channel registers.

---
 rtl/tdm_demux_ctrl.sv | 126 ++++++++++++
 tb/tb_tdm_demux_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_ctrl.sv
// tdm_demux_ctrl: round-robin TDM scheduler driving 1-to-N demux selects with one-hot strobes and frame markers
module tdm_demux_ctrl #(
    parameter int N_CH  = 8,
    parameter int SEL_W = 3,
    parameter int DW    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [N_CH-1:0]  ch_mask,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_data,
    output logic             in_ready,
    output logic [SEL_W-1:0] sel,
    output logic [DW-1:0]    out_data,
    output logic [N_CH-1:0]  ch_strobe,
    output logic             frame_done,
    output logic [7:0]       frame_cnt,
    output logic             busy,
    output logic             err
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_d;
    logic [N_CH-1:0]  mask_q, mask_d;
    logic             stop_pend, stop_d;
    logic [SEL_W-1:0] sel_d;
    logic [DW-1:0]    out_data_d;
    logic [N_CH-1:0]  strobe_d;
    logic             fd_d, err_d, last_beat;
    logic [7:0]       cnt_d;

    function automatic logic [SEL_W-1:0] lowest(input logic [N_CH-1:0] m);
        logic [SEL_W-1:0] r;
        r = '0;
        for (int i = N_CH - 1; i >= 0; i--) if (m[i]) r = SEL_W'(i);
        return r;
    endfunction

    function automatic logic [SEL_W-1:0] highest(input logic [N_CH-1:0] m);
        logic [SEL_W-1:0] r;
        r = '0;
        for (int i = 0; i < N_CH; i++) if (m[i]) r = SEL_W'(i);
        return r;
    endfunction

    // N_CH is a power of two, so the SEL_W-bit add wraps naturally past N_CH-1
    function automatic logic [SEL_W-1:0] next_bit(input logic [N_CH-1:0] m, input logic [SEL_W-1:0] s);
        logic [SEL_W-1:0] r, idx;
        r = s;
        for (int i = N_CH - 1; i >= 1; i--) begin
            idx = s + SEL_W'(i);
            if (m[idx]) r = idx;
        end
        return r;
    endfunction

    assign in_ready  = (state == RUN);
    assign busy      = (state == RUN);
    assign last_beat = (sel == highest(mask_q));

    always_comb begin
        state_d    = state;
        sel_d      = sel;
        mask_d     = mask_q;
        stop_d     = stop_pend;
        out_data_d = out_data;
        strobe_d   = '0;
        fd_d       = 1'b0;
        cnt_d      = frame_cnt;
        err_d      = 1'b0;
        if (state == IDLE) begin
            if (start && ch_mask != '0) begin
                mask_d  = ch_mask;
                sel_d   = lowest(ch_mask);
                stop_d  = stop;
                state_d = RUN;
            end else if (start) begin
                err_d = 1'b1;
            end
        end else begin
            if (stop) stop_d = 1'b1;
            if (in_valid) begin
                out_data_d = in_data;
                strobe_d   = {{(N_CH-1){1'b0}}, 1'b1} << sel;
                sel_d      = next_bit(mask_q, sel);
                if (last_beat) begin
                    fd_d   = 1'b1;
                    cnt_d  = frame_cnt + 8'd1;
                    mask_d = ch_mask;
                    sel_d  = lowest(ch_mask);
                    if (ch_mask == '0 || stop_pend || stop) begin
                        state_d = IDLE;
                        sel_d   = '0;
                        stop_d  = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel        <= '0;
            mask_q     <= '0;
            stop_pend  <= 1'b0;
            out_data   <= '0;
            ch_strobe  <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            err        <= 1'b0;
        end else begin
            state      <= state_d;
            sel        <= sel_d;
            mask_q     <= mask_d;
            stop_pend  <= stop_d;
            out_data   <= out_data_d;
            ch_strobe  <= strobe_d;
            frame_done <= fd_d;
            frame_cnt  <= cnt_d;
            err        <= err_d;
        end
    end
endmodule

// File: tb/tb_tdm_demux_ctrl.sv
// tb_tdm_demux_ctrl: directed self-checking bench for the TDM demux scheduler
module tb_tdm_demux_ctrl;
    logic       clk = 0, rst_n = 0, start = 0, stop = 0, in_valid = 0;
    logic [7:0] ch_mask = 0;
    logic [0:0] in_data = 0;
    logic       in_ready, frame_done, busy, err;
    logic [2:0] sel;
    logic [0:0] out_data;
    logic [7:0] ch_strobe, frame_cnt;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    tdm_demux_ctrl #(.N_CH(8), .SEL_W(3), .DW(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .ch_mask(ch_mask),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .sel(sel),
        .out_data(out_data), .ch_strobe(ch_strobe), .frame_done(frame_done),
        .frame_cnt(frame_cnt), .busy(busy), .err(err)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 0; start = 0; stop = 0; in_valid = 0; in_data = 0; ch_mask = 0;
        step;
        step;
        rst_n = 1;
    endtask

    task automatic launch(input logic [7:0] m, input logic s);
        ch_mask = m; start = 1; stop = s;
        step;
        start = 0; stop = 0;
    endtask

    task automatic test_reset;
        rst_n = 0;
        step;
        step;
        total++;
        if ({sel, in_ready, out_data, ch_strobe, frame_done, frame_cnt, busy, err} !== 24'h0) begin
            bad++; $display("FAIL reset_outputs got %h want 000000", {sel, in_ready, out_data, ch_strobe, frame_done, frame_cnt, busy, err});
        end
        rst_n = 1;
        step;
        total++;
        if ({busy, in_ready} !== 2'b00) begin bad++; $display("FAIL reset_idle got %b want 00", {busy, in_ready}); end
    endtask

    task automatic test_basic_sweep;
        do_reset;
        launch(8'hFF, 0);
        total++;
        if ({busy, in_ready, sel} !== 5'b11_000) begin bad++; $display("FAIL sweep_run got %b want 11000", {busy, in_ready, sel}); end
        in_valid = 1; in_data = 1;
        for (int b = 0; b < 8; b++) begin
            stop = (b == 2);
            total++;
            if (sel !== 3'(b)) begin bad++; $display("FAIL sweep_sel beat%0d got %0d want %0d", b, sel, b); end
            step;
            total++;
            if (ch_strobe !== (8'h01 << b)) begin bad++; $display("FAIL sweep_strobe beat%0d got %h want %h", b, ch_strobe, 8'h01 << b); end
            total++;
            if (frame_done !== (b == 7) || out_data !== 1'b1) begin
                bad++; $display("FAIL sweep_fd_data beat%0d got fd=%b d=%b want fd=%b d=1", b, frame_done, out_data, b == 7);
            end
        end
        stop = 0; in_valid = 0;
        total++;
        if ({busy, in_ready, frame_cnt, sel, err} !== {2'b00, 8'd1, 3'd0, 1'b0}) begin
            bad++; $display("FAIL sweep_end got busy=%b rdy=%b cnt=%0d sel=%0d err=%b want 0 0 1 0 0", busy, in_ready, frame_cnt, sel, err);
        end
        step;
        total++;
        if (ch_strobe !== 8'h00 || frame_done !== 1'b0) begin bad++; $display("FAIL sweep_quiet got strobe=%h fd=%b want 00 0", ch_strobe, frame_done); end
    endtask

    task automatic test_sparse_mask;
        int exp_sel[6] = '{2, 5, 7, 0, 0, 0};
        do_reset;
        launch(8'hA4, 0);
        in_valid = 1;
        for (int b = 0; b < 6; b++) begin
            in_data = 1'(b);
            total++;
            if (sel !== 3'(exp_sel[b])) begin bad++; $display("FAIL sparse_sel beat%0d got %0d want %0d", b, sel, exp_sel[b]); end
            step;
            if (b == 0) ch_mask = 8'h01;
            total++;
            if (ch_strobe !== (8'h01 << exp_sel[b]) || frame_done !== (b >= 2)) begin
                bad++; $display("FAIL sparse_strobe beat%0d got %h/%b want %h/%b", b, ch_strobe, frame_done, 8'h01 << exp_sel[b], b >= 2);
            end
            total++;
            if (out_data !== 1'(b)) begin bad++; $display("FAIL sparse_data beat%0d got %b want %b", b, out_data, 1'(b)); end
        end
        in_valid = 0;
        total++;
        if (frame_cnt !== 8'd4 || busy !== 1'b1) begin bad++; $display("FAIL sparse_cnt got %0d busy=%b want 4 busy=1", frame_cnt, busy); end
    endtask

    task automatic test_backpressure;
        logic v[6] = '{1, 0, 0, 1, 0, 1};
        logic d[6] = '{1, 0, 1, 0, 0, 1};
        logic [2:0] es = 0;
        logic       ed = 0;
        logic [7:0] estb;
        do_reset;
        launch(8'hFF, 0);
        for (int i = 0; i < 6; i++) begin
            in_valid = v[i]; in_data = d[i];
            total++;
            if (sel !== es) begin bad++; $display("FAIL bp_sel cyc%0d got %0d want %0d", i, sel, es); end
            step;
            estb = v[i] ? (8'h01 << es) : 8'h00;
            if (v[i]) begin ed = d[i]; es = es + 3'd1; end
            total++;
            if (ch_strobe !== estb) begin bad++; $display("FAIL bp_strobe cyc%0d got %h want %h", i, ch_strobe, estb); end
            total++;
            if (out_data !== ed) begin bad++; $display("FAIL bp_data cyc%0d got %b want %b", i, out_data, ed); end
        end
        in_valid = 0;
        total++;
        if (sel !== 3'd3) begin bad++; $display("FAIL bp_sel_end got %0d want 3", sel); end
    endtask

    task automatic test_err_simul;
        do_reset;
        launch(8'h00, 0);
        total++;
        if (err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL err_pulse got err=%b busy=%b want 1 0", err, busy); end
        step;
        total++;
        if (err !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL err_single got err=%b busy=%b want 0 0", err, busy); end
        launch(8'h0F, 1);
        total++;
        if (busy !== 1'b1 || sel !== 3'd0 || err !== 1'b0) begin bad++; $display("FAIL simul_start got busy=%b sel=%0d err=%b want 1 0 0", busy, sel, err); end
        in_valid = 1; in_data = 1;
        for (int b = 0; b < 4; b++) begin
            step;
            total++;
            if (ch_strobe !== (8'h01 << b) || frame_done !== (b == 3)) begin
                bad++; $display("FAIL simul_strobe beat%0d got %h/%b want %h/%b", b, ch_strobe, frame_done, 8'h01 << b, b == 3);
            end
        end
        total++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || frame_cnt !== 8'd1) begin
            bad++; $display("FAIL simul_end got busy=%b rdy=%b cnt=%0d want 0 0 1", busy, in_ready, frame_cnt);
        end
        step;
        total++;
        if (ch_strobe !== 8'h00 || frame_done !== 1'b0) begin bad++; $display("FAIL simul_noaccept got %h/%b want 00/0", ch_strobe, frame_done); end
        in_valid = 0;
    endtask

    task automatic test_wrap_reset;
        do_reset;
        launch(8'h01, 0);
        in_valid = 1; in_data = 1;
        for (int b = 0; b < 256; b++) begin
            step;
            total++;
            if (frame_done !== 1'b1 || ch_strobe !== 8'h01 || sel !== 3'd0) begin
                bad++; $display("FAIL wrap_beat%0d got fd=%b strobe=%h sel=%0d want 1 01 0", b, frame_done, ch_strobe, sel);
            end
            if (b == 254) begin
                total++;
                if (frame_cnt !== 8'd255) begin bad++; $display("FAIL wrap_255 got %0d want 255", frame_cnt); end
            end
        end
        total++;
        if (frame_cnt !== 8'd0) begin bad++; $display("FAIL wrap_0 got %0d want 0", frame_cnt); end
        repeat (3) step;
        total++;
        if (frame_cnt !== 8'd3 || busy !== 1'b1) begin bad++; $display("FAIL wrap_more got %0d busy=%b want 3 1", frame_cnt, busy); end
        #2 rst_n = 0;
        #1;
        total++;
        if ({sel, in_ready, out_data, ch_strobe, frame_done, frame_cnt, busy, err} !== 24'h0) begin
            bad++; $display("FAIL async_reset got %h want 000000", {sel, in_ready, out_data, ch_strobe, frame_done, frame_cnt, busy, err});
        end
        step;
        in_valid = 0;
        rst_n = 1;
    endtask

    initial begin
        test_reset;
        test_basic_sweep;
        test_sparse_mask;
        test_backpressure;
        test_err_simul;
        test_wrap_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
